// File: rtl/demux_1x4_collector_pkg.sv
// Shared constants for the 1-to-4 collecting demultiplexer.
// Holds the lane geometry, the frame FSM encoding and the full-mask helper.
package demux_1x4_collector_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;

  localparam logic [0:0] StFilling  = 1'b0;
  localparam logic [0:0] StComplete = 1'b1;

  localparam logic [LANES-1:0] FULL_MASK = {LANES{1'b1}};

  function automatic logic mask_full(input logic [LANES-1:0] mask);
    return mask == FULL_MASK;
  endfunction

endpackage

// File: rtl/demux_1x4_collector_if.sv
// Single-lane input and four-lane output bundle of the collecting demux.
// The testbench drives through master; the design sits behind slave.
interface demux_1x4_collector_if
  import demux_1x4_collector_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             auto_mode;
  logic             s1;
  logic             s2;
  logic             clear;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [LANES-1:0] lane_strobe;
  logic             frame_valid;
  logic             overwrite;
  logic [SEL_W-1:0] lane_ptr;

  modport master (
    output in_valid, in_data, auto_mode, s1, s2, clear,
    input  out0, out1, out2, out3, lane_strobe, frame_valid, overwrite, lane_ptr
  );

  modport slave (
    input  in_valid, in_data, auto_mode, s1, s2, clear,
    output out0, out1, out2, out3, lane_strobe, frame_valid, overwrite, lane_ptr
  );

endinterface

// File: rtl/demux_1x4_collector_lane_decoder_2to4.sv
// 2-to-4 one-hot lane decoder; sel[1] is the MSB (s1), matching the 4x1 mux.
module lane_decoder_2to4
  import demux_1x4_collector_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [LANES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    unique case (sel)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = '0;
    endcase
  end

endmodule

// File: rtl/demux_1x4_collector.sv
// Registered 1-to-4 demux that steers words to lanes and tracks frame fill.
// Emits one-cycle strobe, overwrite and frame-complete pulses.
module demux_1x4_collector
  import demux_1x4_collector_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  demux_1x4_collector_if.slave  bus
);

  logic [WIDTH-1:0] lane_q [LANES];
  logic [LANES-1:0] fill_mask_q;
  logic [LANES-1:0] strobe_q;
  logic [SEL_W-1:0] ptr_q;
  logic             overwrite_q;
  logic [0:0]       state_q;

  logic [SEL_W-1:0] sel;
  logic [LANES-1:0] sel_oh;
  logic [LANES-1:0] mask_or;
  logic             accept;
  logic             hit;
  logic             complete;

  assign sel = bus.auto_mode ? ptr_q : {bus.s1, bus.s2};

  lane_decoder_2to4 u_dec (
    .sel    (sel),
    .onehot (sel_oh)
  );

  assign accept   = bus.in_valid & ~bus.clear;
  assign hit      = |(fill_mask_q & sel_oh);
  assign mask_or  = fill_mask_q | sel_oh;
  // An overwrite leaves the mask unchanged, so it can never finish a frame.
  assign complete = accept & ~hit & mask_full(mask_or);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LANES; i++) begin
        lane_q[i] <= '0;
      end
      fill_mask_q <= '0;
      strobe_q    <= '0;
      ptr_q       <= '0;
      overwrite_q <= 1'b0;
      state_q     <= StFilling;
    end else begin
      strobe_q    <= '0;
      overwrite_q <= 1'b0;
      state_q     <= StFilling;
      if (bus.clear) begin
        fill_mask_q <= '0;
        ptr_q       <= '0;
      end else if (accept) begin
        lane_q[sel] <= bus.in_data;
        strobe_q    <= sel_oh;
        overwrite_q <= hit;
        fill_mask_q <= complete ? '0 : mask_or;
        state_q     <= complete ? StComplete : StFilling;
        if (bus.auto_mode) begin
          ptr_q <= ptr_q + 2'd1;
        end
      end
    end
  end

  assign bus.out0        = lane_q[0];
  assign bus.out1        = lane_q[1];
  assign bus.out2        = lane_q[2];
  assign bus.out3        = lane_q[3];
  assign bus.lane_strobe = strobe_q;
  assign bus.frame_valid = (state_q == StComplete);
  assign bus.overwrite   = overwrite_q;
  assign bus.lane_ptr    = ptr_q;

endmodule

// File: tb/tb_demux_1x4_collector.sv
// Scoreboard bench for demux_1x4_collector: directed steps push hand-computed
// expectations, a negedge monitor pops and compares one record per cycle.
module tb_demux_1x4_collector;

  typedef struct packed {
    logic [15:0] outs;
    logic [3:0]  strobe;
    logic        fv;
    logic        ow;
    logic [1:0]  ptr;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  exp_t sb[$];

  demux_1x4_collector_if #(.WIDTH(4)) bus ();

  demux_1x4_collector #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input exp_t e);
    logic [15:0] outs;
    outs = {bus.out3, bus.out2, bus.out1, bus.out0};
    checks += 5;
    if (outs !== e.outs) begin
      failures++;
      $display("FAIL %s outs got=%h want=%h", name, outs, e.outs);
    end
    if (bus.lane_strobe !== e.strobe) begin
      failures++;
      $display("FAIL %s lane_strobe got=%b want=%b", name, bus.lane_strobe, e.strobe);
    end
    if (bus.frame_valid !== e.fv) begin
      failures++;
      $display("FAIL %s frame_valid got=%b want=%b", name, bus.frame_valid, e.fv);
    end
    if (bus.overwrite !== e.ow) begin
      failures++;
      $display("FAIL %s overwrite got=%b want=%b", name, bus.overwrite, e.ow);
    end
    if (bus.lane_ptr !== e.ptr) begin
      failures++;
      $display("FAIL %s lane_ptr got=%0d want=%0d", name, bus.lane_ptr, e.ptr);
    end
  endtask

  // Monitor: one expectation per clock cycle, sampled mid-period.
  int step_no;
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      step_no++;
      compare($sformatf("step%0d", step_no), e);
    end
  end

  task automatic step(input logic v, input logic [3:0] d, input logic am,
                      input logic [1:0] sel, input logic clr, input logic [15:0] eo,
                      input logic [3:0] es, input logic efv, input logic eow,
                      input logic [1:0] ep);
    exp_t e;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.auto_mode = am;
    bus.s1        = sel[1];
    bus.s2        = sel[0];
    bus.clear     = clr;
    @(posedge clk);
    #1;
    e.outs = eo; e.strobe = es; e.fv = efv; e.ow = eow; e.ptr = ep;
    sb.push_back(e);
    bus.in_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t z;
    checks = 0; failures = 0; step_no = 0;
    z = '0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.auto_mode = 1'b0;
    bus.s1 = 1'b0; bus.s2 = 1'b0; bus.clear = 1'b0;
    #1 reset = 1'b1;
    #1 compare("reset_state", z);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Auto mode, data 1,0,1,1
    step(1, 4'h1, 1, 2'd0, 0, 16'h0001, 4'b0001, 0, 0, 2'd1);
    step(1, 4'h0, 1, 2'd0, 0, 16'h0001, 4'b0010, 0, 0, 2'd2);
    step(1, 4'h1, 1, 2'd0, 0, 16'h0101, 4'b0100, 0, 0, 2'd3);
    step(1, 4'h1, 1, 2'd0, 0, 16'h1101, 4'b1000, 1, 0, 2'd0);
    step(0, 4'h0, 1, 2'd0, 0, 16'h1101, 4'b0000, 0, 0, 2'd0);

    // Manual selects 00,01,10,11; distinct data exposes lane mapping
    step(1, 4'h2, 0, 2'd0, 0, 16'h1102, 4'b0001, 0, 0, 2'd0);
    step(1, 4'h3, 0, 2'd1, 0, 16'h1132, 4'b0010, 0, 0, 2'd0);
    step(1, 4'h4, 0, 2'd2, 0, 16'h1432, 4'b0100, 0, 0, 2'd0);
    step(1, 4'h5, 0, 2'd3, 0, 16'h5432, 4'b1000, 1, 0, 2'd0);
    step(0, 4'h0, 0, 2'd0, 0, 16'h5432, 4'b0000, 0, 0, 2'd0);

    // Lane 1 twice: overwrite, no early frame
    step(1, 4'h6, 0, 2'd1, 0, 16'h5462, 4'b0010, 0, 0, 2'd0);
    step(1, 4'h7, 0, 2'd1, 0, 16'h5472, 4'b0010, 0, 1, 2'd0);
    step(1, 4'h8, 0, 2'd0, 0, 16'h5478, 4'b0001, 0, 0, 2'd0);
    step(1, 4'h9, 0, 2'd2, 0, 16'h5978, 4'b0100, 0, 0, 2'd0);
    step(1, 4'hA, 0, 2'd3, 0, 16'hA978, 4'b1000, 1, 0, 2'd0);

    // Two lanes, then clear with in_valid, then four fresh writes
    step(1, 4'h1, 1, 2'd0, 0, 16'hA971, 4'b0001, 0, 0, 2'd1);
    step(1, 4'h2, 1, 2'd0, 0, 16'hA921, 4'b0010, 0, 0, 2'd2);
    step(1, 4'hF, 1, 2'd0, 1, 16'hA921, 4'b0000, 0, 0, 2'd0);
    step(1, 4'h3, 1, 2'd0, 0, 16'hA923, 4'b0001, 0, 0, 2'd1);
    step(1, 4'h4, 1, 2'd0, 0, 16'hA943, 4'b0010, 0, 0, 2'd2);
    step(1, 4'h5, 1, 2'd0, 0, 16'hA543, 4'b0100, 0, 0, 2'd3);
    step(1, 4'h6, 1, 2'd0, 0, 16'h6543, 4'b1000, 1, 0, 2'd0);

    // Partial frame, then asynchronous reset between edges
    step(1, 4'h7, 1, 2'd0, 0, 16'h6547, 4'b0001, 0, 0, 2'd1);
    step(1, 4'h8, 1, 2'd0, 0, 16'h6587, 4'b0010, 0, 0, 2'd2);
    @(negedge clk);
    #1 reset = 1'b1;
    #1 compare("async_reset", z);
    #1 reset = 1'b0;
    step(0, 4'h0, 1, 2'd0, 0, 16'h0000, 4'b0000, 0, 0, 2'd0);
    step(0, 4'h0, 1, 2'd0, 0, 16'h0000, 4'b0000, 0, 0, 2'd0);

    // A,5,F,0 then 3 immediately; new frame holds only lane 0
    step(1, 4'hA, 1, 2'd0, 0, 16'h000A, 4'b0001, 0, 0, 2'd1);
    step(1, 4'h5, 1, 2'd0, 0, 16'h005A, 4'b0010, 0, 0, 2'd2);
    step(1, 4'hF, 1, 2'd0, 0, 16'h0F5A, 4'b0100, 0, 0, 2'd3);
    step(1, 4'h0, 1, 2'd0, 0, 16'h0F5A, 4'b1000, 1, 0, 2'd0);
    step(1, 4'h3, 1, 2'd0, 0, 16'h0F53, 4'b0001, 0, 0, 2'd1);
    step(1, 4'hC, 0, 2'd0, 0, 16'h0F5C, 4'b0001, 0, 1, 2'd1);
    step(1, 4'hD, 0, 2'd1, 0, 16'h0FDC, 4'b0010, 0, 0, 2'd1);
    step(0, 4'h0, 0, 2'd0, 0, 16'h0FDC, 4'b0000, 0, 0, 2'd1);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
